// File: rtl/ripple_count_checker.sv
// ripple_count_checker: synchronizes and deglitches a 4-bit ripple down-counter and checks its decrement sequence.
// Ports: clk/rst (async active-high) | cnt_in raw ripple count | clr sync clear of checker and statistics
//        cnt_sync last accepted count | step/wrap one-cycle event pulses | wrap_count saturating wraps
//        err sticky sequence error | state 0 INIT, 1 TRACK, 2 FAULT
module ripple_count_checker #(
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cnt_in,
  input  logic              clr,
  output logic [3:0]        cnt_sync,
  output logic              step,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err,
  output logic [1:0]        state
);
  localparam logic [1:0] INIT = 2'd0, TRACK = 2'd1, FAULT = 2'd2;
  localparam logic [3:0] SC = 4'(STABLE_CYCLES);
  logic [3:0] r_s1, r_s2, r_cand, r_stab;
  logic [2:0] r_vld;
  logic [1:0] r_state, w_state_nxt;
  logic [3:0] w_stab_nxt;
  logic       w_acc, w_legal, w_step, w_wrap, w_bad;
  // r_vld marks which of s1/s2/cand hold sampled data rather than reset zeros,
  // so the reset contents are never mistaken for a stable input.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_cand <= '0;
      r_stab <= '0;
      r_vld  <= '0;
    end else begin
      r_s1   <= cnt_in;
      r_s2   <= r_s1;
      r_cand <= r_s2;
      r_stab <= w_stab_nxt;
      r_vld  <= {r_vld[1:0], 1'b1};
    end
  // Accept on the edge where the stability count reaches the window, not one later.
  assign w_stab_nxt = (r_vld[2] && r_s2 == r_cand) ? ((r_stab >= SC) ? SC : r_stab + 4'd1) : 4'd1;
  assign w_acc      = r_vld[1] && w_stab_nxt == SC && (r_s2 != cnt_sync || r_state == INIT);
  assign w_legal    = r_s2 == cnt_sync - 4'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= INIT;
    else     r_state <= w_state_nxt;
  always_comb
    w_state_nxt = clr                                ? INIT  :
                  !w_acc                             ? r_state :
                  r_state == INIT                    ? TRACK :
                  (r_state == TRACK && !w_legal)     ? FAULT : r_state;
  always_comb begin
    w_step = w_acc && !clr && r_state == TRACK && w_legal;
    w_wrap = w_step && cnt_sync == 4'd0;
    w_bad  = w_acc && !clr && r_state == TRACK && !w_legal;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_sync   <= '0;
      step       <= 1'b0;
      wrap       <= 1'b0;
      wrap_count <= '0;
      err        <= 1'b0;
    end else begin
      cnt_sync   <= w_acc ? r_s2 : cnt_sync;
      step       <= w_step;
      wrap       <= w_wrap;
      wrap_count <= clr ? '0 : (w_wrap && !(&wrap_count)) ? wrap_count + 1'b1 : wrap_count;
      err        <= clr ? 1'b0 : (err | w_bad);
    end
  assign state = r_state;
endmodule

// File: tb/tb_ripple_count_checker.sv
// tb_ripple_count_checker: table-driven directed bench for ripple_count_checker.
module tb_ripple_count_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt_in = 4'd0;
  logic       clr = 1'b0;
  logic [3:0] cnt_sync, cnt_sync2;
  logic       step, wrap, err, step2, wrap2, err2;
  logic [7:0] wrap_count;
  logic [1:0] wrap_count2;
  logic [1:0] state, state2;
  int checks = 0, errors = 0, ns = 0, nw = 0;
  logic prev_step = 1'b0;
  typedef struct {
    logic [3:0] v;
    logic       c;
    int         n, cnt, st, er, wc, wc2, steps, wraps;
  } row_t;
  row_t tbl[$];
  always #5 clk = ~clk;
  ripple_count_checker #(.STABLE_CYCLES(2), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr), .cnt_sync(cnt_sync), .step(step),
    .wrap(wrap), .wrap_count(wrap_count), .err(err), .state(state));
  ripple_count_checker #(.STABLE_CYCLES(2), .WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr), .cnt_sync(cnt_sync2), .step(step2),
    .wrap(wrap2), .wrap_count(wrap_count2), .err(err2), .state(state2));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (step) ns++;
    if (wrap) nw++;
    if (step && prev_step) chk("step_back_to_back", 1, 0);
    prev_step = step;
  endtask
  task automatic add(input int v, input int c, input int n, input int cnt, input int st,
                     input int er, input int wc, input int wc2, input int steps, input int wraps);
    row_t r;
    r.v = 4'(v); r.c = c[0]; r.n = n; r.cnt = cnt; r.st = st; r.er = er;
    r.wc = wc; r.wc2 = wc2; r.steps = steps; r.wraps = wraps;
    tbl.push_back(r);
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt_sync"}, int'(cnt_sync), 0);
    chk({tag, "_step"}, int'(step), 0);
    chk({tag, "_wrap"}, int'(wrap), 0);
    chk({tag, "_wrap_count"}, int'(wrap_count), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_wrap_count2"}, int'(wrap_count2), 0);
  endtask
  initial begin
    for (int p = 0; p < 5; p++)
      for (int v = 15; v >= 0; v--)
        add(v, 0, 6, v, 1, 0, p + 1, (p + 1 > 3) ? 3 : p + 1, 1, (v == 15) ? 1 : 0);
    add(15, 0, 6, 15, 1, 0, 6, 3, 1, 1);
    for (int v = 14; v >= 8; v--) add(v, 0, 6, v, 1, 0, 6, 3, 1, 0);
    add(12, 0, 1, 8, 1, 0, 6, 3, 0, 0);
    add(7, 0, 6, 7, 1, 0, 6, 3, 1, 0);
    add(6, 0, 6, 6, 1, 0, 6, 3, 1, 0);
    add(5, 0, 6, 5, 1, 0, 6, 3, 1, 0);
    add(2, 0, 6, 2, 2, 1, 6, 3, 0, 0);
    add(1, 0, 6, 1, 2, 1, 6, 3, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 6, 0, 1, 0, 0, 0, 1, 0);
    add(15, 0, 6, 15, 1, 0, 1, 1, 1, 1);
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("init_edge3_state", int'(state), 0);
    tick();
    chk("init_edge4_state", int'(state), 1);
    chk("init_edge4_cnt", int'(cnt_sync), 0);
    chk("init_steps", ns, 0);
    foreach (tbl[i]) begin
      cnt_in = tbl[i].v;
      clr = tbl[i].c;
      ns = 0;
      nw = 0;
      for (int k = 0; k < tbl[i].n; k++) tick();
      chk($sformatf("row%0d_cnt_sync", i), int'(cnt_sync), tbl[i].cnt);
      chk($sformatf("row%0d_state", i), int'(state), tbl[i].st);
      chk($sformatf("row%0d_err", i), int'(err), tbl[i].er);
      chk($sformatf("row%0d_wrap_count", i), int'(wrap_count), tbl[i].wc);
      chk($sformatf("row%0d_wrap_count2", i), int'(wrap_count2), tbl[i].wc2);
      chk($sformatf("row%0d_steps", i), ns, tbl[i].steps);
      chk($sformatf("row%0d_wraps", i), nw, tbl[i].wraps);
    end
    clr = 1'b0;
    ns = 0;
    for (int v = 14; v >= 9; v--) begin
      cnt_in = 4'(v);
      for (int k = 0; k < 6; k++) tick();
    end
    chk("pre_rst_cnt", int'(cnt_sync), 9);
    chk("pre_rst_steps", ns, 6);
    cnt_in = 4'd8;
    tick();
    tick();
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    tick();
    chk_all_zero("rst_held");
    cnt_in = 4'd9;
    rst = 1'b0;
    ns = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("rerst_edge3_state", int'(state), 0);
    chk("rerst_edge3_cnt", int'(cnt_sync), 0);
    tick();
    chk("rerst_edge4_state", int'(state), 1);
    chk("rerst_edge4_cnt", int'(cnt_sync), 9);
    chk("rerst_steps", ns, 0);
    cnt_in = 4'd8;
    for (int i = 0; i < 3; i++) tick();
    clr = 1'b1;
    tick();
    chk("clr_acc_cnt", int'(cnt_sync), 8);
    chk("clr_acc_state", int'(state), 0);
    chk("clr_acc_steps", ns, 0);
    clr = 1'b0;
    tick();
    chk("clr_acc_next_state", int'(state), 1);
    chk("clr_acc_next_steps", ns, 0);
    cnt_in = 4'd7;
    for (int k = 0; k < 6; k++) tick();
    chk("after_clr_cnt", int'(cnt_sync), 7);
    chk("after_clr_steps", ns, 1);
    chk("after_clr_err", int'(err), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
